// File: rtl/dec_mat_mult_8bit_pkg.sv
// rtl/dec_mat_mult_8bit_pkg.sv - shared types, H matrix and syndrome function for the SECDED decoder multiplier
//
// Purpose : holds the (8,4) extended Hamming parity-check matrix and the
//           GF(2) matrix-vector product used to form the syndrome.
// Contents: codeword_t, syndrome_t, H_ROWS, calc_syndrome().
package dec_mat_pkg;

  typedef logic [7:0] codeword_t;
  typedef logic [3:0] syndrome_t;

  // Row k of H, MSB..LSB = codeword bits 7..0. Column i works out to {1'b1, i[2:0]},
  // so a single-bit error at position i yields syndrome {1, i}.
  localparam codeword_t H_ROWS[4] = '{
    8'b1010_1010,   // H[0]
    8'b1100_1100,   // H[1]
    8'b1111_0000,   // H[2]
    8'b1111_1111    // H[3], overall parity
  };

  function automatic syndrome_t calc_syndrome(codeword_t c);
    syndrome_t s;
    for (int k = 0; k < 4; k++) begin
      s[k] = ^(c & H_ROWS[k]);
    end
    return s;
  endfunction

endpackage

// File: rtl/dec_mat_mult_8bit_if.sv
// rtl/dec_mat_mult_8bit_if.sv - codeword-in / syndrome-out bus of the decoder matrix multiplier
//
// Purpose : groups the input qualifier/codeword and the registered syndrome outputs.
// Signals : in_valid, codeword_with_errors      (master -> slave)
//           mul_result, out_valid,
//           err_single, err_double              (slave -> master)
interface dec_mat_mult_8bit_if;
  import dec_mat_pkg::*;

  logic      in_valid;
  codeword_t codeword_with_errors;
  syndrome_t mul_result;
  logic      out_valid;
  logic      err_single;
  logic      err_double;

  modport master (
    output in_valid, codeword_with_errors,
    input  mul_result, out_valid, err_single, err_double
  );

  modport slave (
    input  in_valid, codeword_with_errors,
    output mul_result, out_valid, err_single, err_double
  );

endinterface

// File: rtl/dec_mat_mult_8bit_syndrome_calc.sv
// rtl/dec_mat_mult_8bit_syndrome_calc.sv - combinational H x c syndrome over GF(2)
//
// Purpose : pure XOR network; no state.
// Ports   : codeword  in  8  received codeword
//           syndrome  out 4  S = H x codeword
module dec_syndrome_calc
  import dec_mat_pkg::*;
(
  input  codeword_t codeword,
  output syndrome_t syndrome
);

  assign syndrome = calc_syndrome(codeword);

endmodule

// File: rtl/dec_mat_mult_8bit.sv
// rtl/dec_mat_mult_8bit.sv - registered SECDED syndrome and error classification
//
// Purpose : computes S = H x c on each valid codeword, registers S one cycle
//           later together with single/double error flags.
// Ports   : clk    in   1  system clock, rising edge
//           rst_n  in   1  asynchronous active-low reset
//           bus    slave modport of dec_mat_mult_8bit_if
//                  (in_valid, codeword_with_errors -> mul_result, out_valid,
//                   err_single, err_double)
module dec_mat_mult_8bit
  import dec_mat_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  dec_mat_mult_8bit_if.slave   bus
);

  codeword_t cw_qual;
  syndrome_t syn;
  syndrome_t mul_result_q;
  logic      out_valid_q;
  logic      err_single_q;
  logic      err_double_q;

  // Mask the codeword when not valid so an undriven bus never reaches the XOR tree.
  assign cw_qual = bus.in_valid ? bus.codeword_with_errors : '0;

  dec_syndrome_calc u_syndrome_calc (
    .codeword (cw_qual),
    .syndrome (syn)
  );

  // Result and flags hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_result_q <= '0;
      out_valid_q  <= 1'b0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        mul_result_q <= syn;
        // Odd overall parity means an odd-weight (correctable) error, including
        // S = 4'b1000 which points at bit 0.
        err_single_q <= syn[3];
        err_double_q <= ~syn[3] & (|syn[2:0]);
      end
    end
  end

  assign bus.mul_result = mul_result_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;

endmodule

// File: tb/tb_dec_mat_mult_8bit.sv
// tb/tb_dec_mat_mult_8bit.sv - scoreboard bench for the SECDED syndrome multiplier
module tb_dec_mat_mult_8bit;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int         cyc;
    logic [3:0] syn;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] last_exp;

  dec_mat_mult_8bit_if bus ();

  dec_mat_mult_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: syndrome is {parity of the codeword, XOR of indices of set bits}.
  function automatic logic [3:0] model_syn(input logic [7:0] c);
    logic [2:0] pos;
    logic       par;
    pos = '0;
    par = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin
        pos ^= 3'(i);
        par = ~par;
      end
    end
    return {par, pos};
  endfunction

  task automatic send(input logic [7:0] cw, input logic [3:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid             = 1'b1;
    bus.codeword_with_errors = cw;
    e.cyc = cyc;
    e.syn = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid             = 1'b0;
      bus.codeword_with_errors = 8'($urandom);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mul_result"}, 32'(bus.mul_result), 32'h0);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'h0);
    check({tag, "_err_single"}, 32'(bus.err_single), 32'h0);
    check({tag, "_err_double"}, 32'(bus.err_double), 32'h0);
  endtask

  // Assert reset away from any clock edge, after a result has just been registered.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    sb_q.delete();
    last_exp = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: every falling edge, decide from the scoreboard whether a result is due.
  always @(negedge clk) begin
    logic       due;
    logic [3:0] s;
    exp_t       e;
    if (rst_n) begin
      due = (sb_q.size() > 0) && (sb_q[0].cyc + 1 == cyc);
      check("out_valid", 32'(bus.out_valid), 32'(due));
      if (due) begin
        e = sb_q.pop_front();
        s = e.syn;
        last_exp = s;
        check("mul_result", 32'(bus.mul_result), 32'(s));
      end else begin
        s = last_exp;
        check("hold_mul_result", 32'(bus.mul_result), 32'(s));
      end
      check("err_single", 32'(bus.err_single), 32'(s[3]));
      check("err_double", 32'(bus.err_double), 32'(!s[3] && (s[2:0] != 3'b000)));
      if (bus.err_single && bus.err_double)
        check("flags_exclusive", 32'h1, 32'h0);
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] one_hot;
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    bus.in_valid             = 1'b0;
    bus.codeword_with_errors = '0;

    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset_state");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(2);

    // Directed vectors with known syndromes, separated by idle cycles to exercise hold.
    send(8'b1000_1010, 4'b1101); idle(2);
    send(8'b0000_0000, 4'b0000); idle(1);
    send(8'b1111_1111, 4'b0000); idle(1);
    send(8'b0000_0100, 4'b1010); idle(2);
    send(8'b0000_0011, 4'b0001); idle(2);
    send(8'b0000_0001, 4'b1000); idle(1);

    // Single-bit sweep, back to back.
    for (int i = 0; i < 8; i++) begin
      one_hot = 8'b1 << i;
      send(one_hot, {1'b1, 3'(i)});
    end
    idle(2);

    // Back-to-back pair.
    send(8'b1000_1010, 4'b1101);
    send(8'b0000_0011, 4'b0001);
    idle(2);

    // Randomized stream with random gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        r = 8'($urandom);
        send(r, model_syn(r));
      end else begin
        idle(1);
      end
    end

    // Reset mid-stream, then stay idle: outputs must remain zero.
    send(8'b1000_1010, 4'b1101);
    send(8'b0111_0110, model_syn(8'b0111_0110));
    mid_reset();
    idle(3);
    check_zero_outputs("post_reset_idle");

    // Traffic resumes normally after reset.
    for (int n = 0; n < 40; n++) begin
      r = 8'($urandom);
      send(r, model_syn(r));
    end
    idle(3);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
